// File: rtl/add_result_drain.sv
// add_result_drain
// Output stage for the 2-stage registered adder pipeline (x + y -> out, no
// valid signalling). A valid-shadow shift register tracks which adder launches
// were real; their sums land in a small FIFO that is drained over a
// ready/valid port. The issuer gets credit (issue_ready) so results already in
// flight always have a FIFO slot waiting for them.
//
// Parameter constraints: LATENCY >= 1 and equal to the adder depth;
// DEPTH a power of two, >= 2 (pointers wrap by natural overflow).

module add_result_drain #(
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 2,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         issue_valid,
    output logic                         issue_ready,
    input  logic [DATA_WIDTH-1:0]        sum,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic                         overflow_err
);

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    // Wide enough for count + every shadow bit without wrapping.
    localparam int CRED_W = $clog2(DEPTH + LATENCY + 1);

    logic [LATENCY-1:0]    shadow;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [CRED_W-1:0]     inflight;
    logic [CRED_W-1:0]     committed;

    logic accept;
    logic push;
    logic pop;

    // ------------------------------------------------------------------
    // Credit: every result either sits in the FIFO or is still travelling
    // down the adder (one shadow bit each). Only registers feed this, so
    // there is no combinational path from out_ready or issue_valid, and a
    // slot freed by a pop shows up as credit one cycle later.
    // ------------------------------------------------------------------

    // Count the results still travelling through the adder.
    always_comb begin
        // NOTE: assign a default before the loop so every path drives the
        // signal and no latch is inferred.
        inflight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            inflight = inflight + CRED_W'(shadow[i]);
        end
    end

    assign committed   = CRED_W'(count) + inflight;
    assign issue_ready = committed < CRED_W'(DEPTH);

    assign accept = issue_valid && issue_ready;
    assign push   = shadow[LATENCY-1];
    assign pop    = out_valid && out_ready;

    // ------------------------------------------------------------------
    // Valid shadow: bit LATENCY-1 is high exactly in the cycle the adder
    // output carries an accepted launch. A refused issue shifts in 0, so
    // its sum is simply never captured.
    // ------------------------------------------------------------------
    generate
        if (LATENCY == 1) begin : g_shadow_single
            // Single-stage shadow: one bit mirrors last cycle's accept.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    shadow <= '0;
                end else begin
                    // NOTE: sequential state uses non-blocking assignments
                    // so every flop samples pre-edge values.
                    shadow[0] <= accept;
                end
            end
        end else begin : g_shadow_shift
            // Multi-stage shadow: shift the accept flag along with the adder.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    shadow <= '0;
                end else begin
                    shadow <= {shadow[LATENCY-2:0], accept};
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------

    // Capture the adder sum whenever the shadow marks it as real.
    // NOTE: the data array has no reset; contents behind an invalid pointer
    // are never observed, and leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= sum;
        end
    end

    // Advance the write pointer on each push; wraps modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
        end
    end

    // Advance the read pointer on each pop; wraps modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
        end else if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // Track FIFO occupancy; a simultaneous push and pop cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky flag for an issue attempted without credit; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_err <= 1'b0;
        end else if (issue_valid && !issue_ready) begin
            overflow_err <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all derived from registered state. out_data reads the head
    // slot directly; there is no bypass from sum, so a result is visible
    // the cycle after it is pushed.
    // ------------------------------------------------------------------
    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];
    assign occupancy = count;

    // ------------------------------------------------------------------
    // Invariants guaranteed by the credit scheme.
    // ------------------------------------------------------------------

    // A push always finds a free slot, because its credit was reserved at issue.
    a_no_push_when_full : assert property (
        @(posedge clk) disable iff (!rst_n)
        push |-> (count < CNT_W'(DEPTH))
    );

    // Buffered plus in-flight results never exceed the FIFO size.
    a_credit_bound : assert property (
        @(posedge clk) disable iff (!rst_n)
        committed <= CRED_W'(DEPTH)
    );

endmodule
